fetch_predict: RTL
==================

FETCH_PREDICT -- requirements
Module: fetch_predict

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded by reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high.
REQ-004 stall_if  input  1  hold PC and IF/ID registers.
REQ-005 flush_id  input  1  external IF/ID clear request.
REQ-006 id_branch, id_pc_src, id_jump  input  1 each  decode-stage branch present / resolved taken / jump.
REQ-007 id_pc_branch, id_pc_jump  input  32 each  decode-stage branch and jump targets.
REQ-008 pred_update_en, pred_update_taken  input  1 each; pred_update_index  input  8  direction-predictor update.
REQ-009 btb_update_en  input  1; btb_update_index  input  6; btb_update_tag  input  20; btb_update_target  input  32  BTB write.
REQ-010 imem_addr  output  32  current PC to instruction memory; imem_rdata  input  32  combinational read data.
REQ-011 if_id_instr, if_id_pc, if_id_pc_plus_4  output  32 each  IF/ID pipeline register.
REQ-012 if_id_pred_taken  output  1  prediction made for instruction in IF/ID.

Function
REQ-013 Predictor: 256 x 2-bit saturating counters indexed PC[9:2]; counter >= 2'b10 means predict taken.
REQ-014 BTB: 64 entries {valid, tag[19:0], target[31:0]}, indexed PC[11:6]; hit = valid && tag == PC[31:12].
REQ-015 pred_taken = counter_taken && btb_hit, computed combinationally from current PC in the same cycle.
REQ-016 redirect_target: id_jump -> id_pc_jump; else id_branch && id_pc_src && !if_id_pred_taken -> id_pc_branch; else id_branch && !id_pc_src && if_id_pred_taken -> if_id_pc_plus_4.
REQ-017 redirect asserted when any REQ-016 case holds and stall_if == 0; redirect is ignored while stall_if == 1.
REQ-018 Next-PC priority: reset > redirect > stall_if (hold) > pred_taken (BTB target) > PC + 4.
REQ-019 PC + 4 wraps modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-020 IF/ID update, one-cycle latency: reset, redirect or flush_id -> all IF/ID outputs 0; else stall_if -> hold; else load {imem_rdata, PC, PC+4, pred_taken}.
REQ-021 Counter update when pred_update_en && !stall_if: taken -> increment saturating at 2'b11; not taken -> decrement saturating at 2'b00.
REQ-022 BTB write when btb_update_en && !stall_if: entry <= {1, tag, target}; an existing entry at that index is overwritten.
REQ-023 Read/update of the same index in the same cycle: the read returns the pre-update value, and the update is visible next cycle.
REQ-024 Predictor and BTB updates are applied in a redirect cycle (they are not suppressed by their own redirect).
REQ-025 imem_addr equals the PC register at all times.

Reset
REQ-026 On reset: PC = RESET_PC; IF/ID outputs all 0; all counters = 2'b01; all BTB valid bits = 0; targets and tags are don't-care.
REQ-027 Reset asserted mid-operation overrides redirect, stall and pending updates in that cycle.
REQ-028 The first fetch after reset deassertion is from RESET_PC, with pred_taken = 0.

Verification
REQ-029 Sequential fetch: reset, then 4 cycles with no stall -> imem_addr 0, 4, 8, 12; if_id_pc lags by one cycle; if_id_pc_plus_4 = if_id_pc + 4.
REQ-030 Training: two updates of index 8'h04 taken plus a BTB write {idx 6'h00, tag 0, target 32'h100}; fetch PC 32'h10 -> next imem_addr 32'h100; if_id_pred_taken = 1.
REQ-031 Mispredict-taken: if_id_pred_taken = 1, id_branch = 1, id_pc_src = 0, if_id_pc_plus_4 = 32'h14 -> next PC 32'h14; IF/ID cleared.
REQ-032 Jump under stall: id_jump = 1 with stall_if = 1 -> PC and IF/ID hold; stall_if drops -> PC = id_pc_jump; IF/ID cleared.
REQ-033 Saturation: three not-taken updates from reset on one index -> counter 2'b00; five taken updates -> 2'b11; same-cycle read returns the old value.
REQ-034 Reset mid-redirect: reset and id_jump high together -> PC = RESET_PC; counters = 2'b01; BTB invalid.

Source files
------------

// File: rtl/fetch_predict.sv
// Instruction fetch stage with a 2-bit direction predictor, a direct-mapped BTB
// and the IF/ID pipeline register.
module fetch_predict #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall_if,
    input  logic        i_flush_id,
    input  logic        i_id_branch,
    input  logic        i_id_pc_src,
    input  logic        i_id_jump,
    input  logic [31:0] i_id_pc_branch,
    input  logic [31:0] i_id_pc_jump,
    input  logic        i_pred_update_en,
    input  logic        i_pred_update_taken,
    input  logic [7:0]  i_pred_update_index,
    input  logic        i_btb_update_en,
    input  logic [5:0]  i_btb_update_index,
    input  logic [19:0] i_btb_update_tag,
    input  logic [31:0] i_btb_update_target,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_if_id_instr,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_pc_plus_4,
    output logic        o_if_id_pred_taken
);

    logic [31:0] r_pc;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_pc_plus_4;
    logic        r_if_id_pred_taken;

    logic [1:0]  r_ctr        [256];
    logic        r_btb_valid  [64];
    logic [19:0] r_btb_tag    [64];
    logic [31:0] r_btb_target [64];

    logic [31:0] w_pc_plus_4;
    logic [1:0]  w_ctr;
    logic [5:0]  w_btb_idx;
    logic        w_btb_hit;
    logic        w_pred_taken;
    logic        w_redirect_case;
    logic [31:0] w_redirect_target;
    logic        w_redirect;
    logic [31:0] w_next_pc;
    logic        w_if_id_clear;

    assign w_pc_plus_4  = r_pc + 32'd4;
    assign w_ctr        = r_ctr[r_pc[9:2]];
    assign w_btb_idx    = r_pc[11:6];
    assign w_btb_hit    = r_btb_valid[w_btb_idx] && (r_btb_tag[w_btb_idx] == r_pc[31:12]);
    assign w_pred_taken = w_ctr[1] && w_btb_hit;

    // Decode-stage resolution: jumps always redirect, branches only when the
    // prediction carried in IF/ID turned out wrong.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        w_redirect_case   = 1'b1;
        w_redirect_target = 32'h0;
        if (i_id_jump) begin
            w_redirect_target = i_id_pc_jump;
        end else if (i_id_branch && i_id_pc_src && !r_if_id_pred_taken) begin
            w_redirect_target = i_id_pc_branch;
        end else if (i_id_branch && !i_id_pc_src && r_if_id_pred_taken) begin
            w_redirect_target = r_if_id_pc_plus_4;
        end else begin
            w_redirect_case = 1'b0;
        end
    end

    assign w_redirect    = w_redirect_case && !i_stall_if;
    assign w_if_id_clear = w_redirect || i_flush_id;

    always_comb begin
        w_next_pc = w_pc_plus_4;
        if (w_redirect) begin
            w_next_pc = w_redirect_target;
        end else if (i_stall_if) begin
            w_next_pc = r_pc;
        end else if (w_pred_taken) begin
            w_next_pc = r_btb_target[w_btb_idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc               <= RESET_PC;
            r_if_id_instr      <= 32'h0;
            r_if_id_pc         <= 32'h0;
            r_if_id_pc_plus_4  <= 32'h0;
            r_if_id_pred_taken <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            if (w_if_id_clear) begin
                r_if_id_instr      <= 32'h0;
                r_if_id_pc         <= 32'h0;
                r_if_id_pc_plus_4  <= 32'h0;
                r_if_id_pred_taken <= 1'b0;
            end else if (!i_stall_if) begin
                r_if_id_instr      <= i_imem_rdata;
                r_if_id_pc         <= r_pc;
                r_if_id_pc_plus_4  <= w_pc_plus_4;
                r_if_id_pred_taken <= w_pred_taken;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 256; i++) r_ctr[i] <= 2'b01;
        end else if (i_pred_update_en && !i_stall_if) begin
            if (i_pred_update_taken) begin
                if (r_ctr[i_pred_update_index] != 2'b11)
                    r_ctr[i_pred_update_index] <= r_ctr[i_pred_update_index] + 2'd1;
            end else if (r_ctr[i_pred_update_index] != 2'b00) begin
                r_ctr[i_pred_update_index] <= r_ctr[i_pred_update_index] - 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 64; i++) r_btb_valid[i] <= 1'b0;
        end else if (i_btb_update_en && !i_stall_if) begin
            r_btb_valid[i_btb_update_index] <= 1'b1;
        end
    end

    // NOTE: tag/target storage has no reset; an entry is only consulted once its valid bit is set.
    always_ff @(posedge i_clk) begin
        if (!i_reset && i_btb_update_en && !i_stall_if) begin
            r_btb_tag[i_btb_update_index]    <= i_btb_update_tag;
            r_btb_target[i_btb_update_index] <= i_btb_update_target;
        end
    end

    assign o_imem_addr        = r_pc;
    assign o_if_id_instr      = r_if_id_instr;
    assign o_if_id_pc         = r_if_id_pc;
    assign o_if_id_pc_plus_4  = r_if_id_pc_plus_4;
    assign o_if_id_pred_taken = r_if_id_pred_taken;

endmodule
